data_sync: RTL

- Destination-domain synchronizer for a multi-bit bus driven from another clock domain.
- The source holds `unsync_bus` stable and raises the level qualifier `bus_enable`.
- This block:
  - synchronizes `bus_enable` through a flop chain;
  - turns the synchronized rising edge into a single-cycle strobe;
  - captures the bus into a holding register;
  - presents the captured word to the local consumer with a valid/ready handshake and overrun detection.
- It sits directly downstream of the level-to-pulse stage pattern and feeds local-domain logic such as the register file or ALU front end.

---
 rtl/data_sync_if.sv | 25 ++
 rtl/data_sync.sv | 82 ++++++++
 2 files changed

// File: rtl/data_sync_if.sv
// Handshake and data bundle between the source/consumer side and the data_sync
// destination-domain synchronizer.
interface data_sync_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 bus_enable;
    logic                 sync_ready;
    logic                 clr_overrun;
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 enable_pulse;
    logic                 sync_valid;
    logic                 overrun;

    // Source word, consumer ready and overrun clear come in; captured word goes out.
    modport master (
        output unsync_bus, bus_enable, sync_ready, clr_overrun,
        input  sync_bus, enable_pulse, sync_valid, overrun
    );

    modport slave (
        input  unsync_bus, bus_enable, sync_ready, clr_overrun,
        output sync_bus, enable_pulse, sync_valid, overrun
    );
endinterface

// File: rtl/data_sync.sv
// Destination-domain capture of a multi-bit bus qualified by a level enable:
// flop-chain sync of the enable, rising-edge strobe, holding register, valid/ready.
module data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    data_sync_if.slave bus
);

    if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
        $error("data_sync: NUM_STAGES must be in 2..4");
    end

    logic [NUM_STAGES-1:0] sync_q;
    logic                  prev_q;
    logic                  s_out;
    logic                  new_word;

    logic [BUS_WIDTH-1:0]  sync_bus_q;
    logic                  enable_pulse_q;
    logic                  sync_valid_q;
    logic                  overrun_q;

    assign s_out    = sync_q[NUM_STAGES-1];
    assign new_word = s_out & ~prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], bus.bus_enable};
            prev_q <= s_out;
        end
    end

    // NOTE: the data bus is never passed through the flop chain; it is only
    // sampled once the synchronized enable proves it has been stable for cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
        end else begin
            enable_pulse_q <= new_word;
            if (new_word) begin
                sync_bus_q <= bus.unsync_bus;
            end
        end
    end

    // A capture always wins over a consume; the word stays valid across the swap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_valid_q <= 1'b0;
        end else if (new_word) begin
            sync_valid_q <= 1'b1;
        end else if (sync_valid_q && bus.sync_ready) begin
            sync_valid_q <= 1'b0;
        end
    end

    // Sticky overrun: set on capture over an unconsumed word, set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (new_word && sync_valid_q && !bus.sync_ready) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.sync_bus     = sync_bus_q;
    assign bus.enable_pulse = enable_pulse_q;
    assign bus.sync_valid   = sync_valid_q;
    assign bus.overrun      = overrun_q;

endmodule
